// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multicycle MIPS controller.
// Holds FSM state codes, ALU operation codes, opcode/funct values and the
// datapath mux select encodings used by the controller and its decoder.
package mips_ctrl_pkg;
    localparam logic [3:0] S_BOOT     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMRD    = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWR    = 4'd6;
    localparam logic [3:0] S_RTYPE_EX = 4'd7;
    localparam logic [3:0] S_RTYPE_WB = 4'd8;
    localparam logic [3:0] S_IMM_EX   = 4'd9;
    localparam logic [3:0] S_IMM_WB   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_JAL      = 4'd13;
    localparam logic [3:0] S_JR       = 4'd14;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;
    localparam logic [3:0] ALU_SRLV = 4'd12;
    localparam logic [3:0] ALU_SRAV = 4'd13;
    localparam logic [3:0] ALU_LUI  = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;
    localparam logic [1:0] SRCB_BR  = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
// master = controller (drives control and status), slave = datapath side
// (drives opcode, funct, zero flag and memory ready).
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       illegal;
    logic       mem_err;
    logic       halted;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_control,
               pc_source, illegal, mem_err, halted
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_control,
               pc_source, illegal, mem_err, halted
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// mips_alu_decode: combinational opcode/funct to ALU operation decoder.
// Ports: opcode_i/funct_i instruction fields; alu_control_o ALU op code;
// zero_ext_o immediate is zero-extended; funct_valid_o R-type funct is known.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       zero_ext_o,
    output logic       funct_valid_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        funct_valid_o = 1'b1;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                F_ADD, F_ADDU, F_JR: alu_control_o = ALU_ADD;
                F_SUB, F_SUBU:       alu_control_o = ALU_SUB;
                F_AND:               alu_control_o = ALU_AND;
                F_OR:                alu_control_o = ALU_OR;
                F_XOR:               alu_control_o = ALU_XOR;
                F_NOR:               alu_control_o = ALU_NOR;
                F_SLT:               alu_control_o = ALU_SLT;
                F_SLTU:              alu_control_o = ALU_SLTU;
                F_SLL:               alu_control_o = ALU_SLL;
                F_SRL:               alu_control_o = ALU_SRL;
                F_SRA:               alu_control_o = ALU_SRA;
                F_SLLV:              alu_control_o = ALU_SLLV;
                F_SRLV:              alu_control_o = ALU_SRLV;
                F_SRAV:              alu_control_o = ALU_SRAV;
                default:             funct_valid_o = 1'b0;
            endcase
        end else begin
            case (opcode_i)
                OP_BEQ, OP_BNE:  alu_control_o = ALU_SUB;
                OP_ANDI:         alu_control_o = ALU_AND;
                OP_ORI:          alu_control_o = ALU_OR;
                OP_XORI:         alu_control_o = ALU_XOR;
                OP_SLTI:         alu_control_o = ALU_SLT;
                OP_SLTIU:        alu_control_o = ALU_SLTU;
                OP_LUI:          alu_control_o = ALU_LUI;
                default:         alu_control_o = ALU_ADD;
            endcase
        end
    end

    assign zero_ext_o = opcode_i inside {OP_ANDI, OP_ORI, OP_XORI};
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM controller for a shared-memory multicycle MIPS.
// Ports: clk, rst_n (async active-low); bus (master modport) carries the
// instruction fields, zero flag and memory handshake in, and all datapath
// controls plus sticky illegal/mem_err and halted status out.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT     = 255,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mips_multicycle_ctrl_if.master   bus
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Trap fires on the wait cycle that would bring the count to MEM_TIMEOUT.
    localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d, mem_err_q, mem_err_d;
    logic [3:0]    dec_alu;
    logic          dec_zext, funct_ok, req, stall, tmo;

    mips_alu_decode u_dec (
        .opcode_i      (bus.opcode),
        .funct_i       (bus.funct),
        .alu_control_o (dec_alu),
        .zero_ext_o    (dec_zext),
        .funct_valid_o (funct_ok)
    );

    assign req   = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign stall = req && !bus.mem_ready;
    assign tmo   = (MEM_TIMEOUT != 0) && stall && (cnt_q == LIM);
    assign cnt_d = stall ? cnt_q + 1'b1 : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:     state_d = S_FETCH;
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : (tmo ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = (bus.funct == F_JR) ? S_JR : S_RTYPE_EX;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                                    state_d = S_IMM_EX;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = bus.mem_ready ? S_MEMWB : (tmo ? S_TRAP : S_MEMRD);
            S_MEMWR:    state_d = bus.mem_ready ? S_FETCH : (tmo ? S_TRAP : S_MEMWR);
            S_RTYPE_EX: state_d = funct_ok ? S_RTYPE_WB : S_TRAP;
            S_IMM_EX:   state_d = S_IMM_WB;
            S_TRAP:     state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // A trap leaving DECODE or RTYPE_EX is always an instruction fault.
    assign illegal_d = illegal_q || ((state_q == S_DECODE || state_q == S_RTYPE_EX) && state_d == S_TRAP);
    assign mem_err_d = mem_err_q || tmo;

    always_comb begin
        bus.mem_req     = req;
        bus.mem_we      = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = DST_RT;
        bus.mem_to_reg  = M2R_ALU;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_B;
        bus.zero_ext    = 1'b0;
        bus.alu_control = ALU_ADD;
        bus.pc_source   = PCS_ALU;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = SRCB_4;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = SRCB_BR;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD:    bus.iord = 1'b1;
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                bus.iord   = 1'b1;
                bus.mem_we = 1'b1;
            end
            S_RTYPE_EX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = dec_alu;
            end
            S_RTYPE_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = DST_RD;
            end
            S_IMM_EX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_control = dec_alu;
                bus.zero_ext    = dec_zext;
            end
            S_IMM_WB:   bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.pc_source   = PCS_ALUOUT;
                bus.pc_write    = bus.zero ^ (bus.opcode == OP_BNE);
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_JUMP;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCS_JUMP;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = DST_RA;
                bus.mem_to_reg = M2R_PC;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCS_REGA;
            end
            default: ;
        endcase
    end

    assign bus.illegal = illegal_q;
    assign bus.mem_err = mem_err_q;
    assign bus.halted  = HALT_ON_ILLEGAL && (state_q == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed bench for mips_multicycle_ctrl.
// u0: MEM_TIMEOUT=4, halting trap; u1: MEM_TIMEOUT=255, resuming trap.
// Both DUTs share one stimulus stream; inputs change right after a falling
// edge and outputs are sampled 1 time unit later.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if b0 ();
    mips_multicycle_ctrl_if b1 ();

    assign b0.opcode = opcode;
    assign b0.funct = funct;
    assign b0.zero = zero;
    assign b0.mem_ready = mem_ready;
    assign b1.opcode = opcode;
    assign b1.funct = funct;
    assign b1.zero = zero;
    assign b1.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.master));
    mips_multicycle_ctrl #(.MEM_TIMEOUT(255), .HALT_ON_ILLEGAL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.master));

    wire [25:0] o0 = {b0.mem_req, b0.mem_we, b0.iord, b0.ir_write, b0.pc_write, b0.reg_write,
                      b0.reg_dst, b0.mem_to_reg, b0.alu_src_a, b0.alu_src_b, b0.zero_ext,
                      b0.alu_control, b0.pc_source, b0.illegal, b0.mem_err, b0.halted};
    wire [25:0] o1 = {b1.mem_req, b1.mem_we, b1.iord, b1.ir_write, b1.pc_write, b1.reg_write,
                      b1.reg_dst, b1.mem_to_reg, b1.alu_src_a, b1.alu_src_b, b1.zero_ext,
                      b1.alu_control, b1.pc_source, b1.illegal, b1.mem_err, b1.halted};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("rst_o0", 32'(o0), 0);
        chk("rst_o1", 32'(o1), 0);
        nx(); nx();
        chk("rst_hold_o1", 32'(o1), 0);
        rst_n = 1'b1;
        #1 chk("boot_req", 32'(b1.mem_req), 0);
        // LW, zero-wait
        nx(); opcode = OP_LW;
        #1 chk("fetch_req", 32'(b1.mem_req), 1);
        chk("fetch_iord", 32'(b1.iord), 0);
        chk("fetch_ir_write", 32'(b1.ir_write), 1);
        chk("fetch_src_b", 32'(b1.alu_src_b), 1);
        nx(); #1 chk("dec_src_b", 32'(b1.alu_src_b), 3);
        chk("dec_req", 32'(b1.mem_req), 0);
        nx(); #1 chk("memadr_src", 32'({b1.alu_src_a, b1.alu_src_b}), 3'b110);
        nx(); #1 chk("memrd_req_iord", 32'({b1.mem_req, b1.iord, b1.reg_write}), 3'b110);
        nx(); #1 chk("memwb_rw", 32'(b1.reg_write), 1);
        chk("memwb_m2r", 32'(b1.mem_to_reg), 1);
        // FETCH with 3 wait cycles, then BNE zero=0
        nx(); mem_ready = 1'b0; opcode = OP_BNE; zero = 1'b0;
        #1 chk("wfetch_req", 32'(b1.mem_req), 1);
        chk("wfetch_iord", 32'(b1.iord), 0);
        chk("wfetch_ir0", 32'({b1.ir_write, b1.pc_write}), 0);
        for (int i = 0; i < 2; i++) begin
            nx(); #1 chk("wait_req_ir", 32'({b1.mem_req, b1.ir_write, b1.pc_write}), 3'b100);
        end
        nx(); mem_ready = 1'b1;
        #1 chk("wait_done_u1", 32'({b1.mem_req, b1.ir_write, b1.pc_write}), 3'b111);
        chk("wait_done_u0", 32'({b0.mem_req, b0.ir_write, b0.pc_write}), 3'b111);
        nx(); #1 chk("limit_ok_u0", 32'({b0.mem_req, b0.alu_src_b, b0.mem_err}), 3'b0110);
        nx(); #1 chk("bne_pcw", 32'(b1.pc_write), 1);
        chk("bne_pcsrc", 32'(b1.pc_source), 1);
        chk("bne_alu", 32'(b1.alu_control), 1);
        // BEQ, zero low then high
        nx(); opcode = OP_BEQ;
        #1 chk("beq_fetch", 32'(b1.mem_req), 1);
        nx();
        nx(); #1 chk("beq_z0_pcw", 32'(b1.pc_write), 0);
        zero = 1'b1;
        #1 chk("beq_z1_pcw", 32'(b1.pc_write), 1);
        // JAL
        nx(); zero = 1'b0; opcode = OP_JAL;
        nx();
        nx(); #1 chk("jal_dst", 32'(b1.reg_dst), 2);
        chk("jal_m2r", 32'(b1.mem_to_reg), 2);
        chk("jal_pcw_src", 32'({b1.pc_write, b1.pc_source, b1.reg_write}), 4'b1101);
        // R-type SRAV
        nx(); opcode = OP_RTYPE; funct = F_SRAV;
        nx();
        nx(); #1 chk("rex_alu", 32'(b1.alu_control), 13);
        chk("rex_src", 32'({b1.alu_src_a, b1.alu_src_b}), 3'b100);
        nx(); #1 chk("rwb", 32'({b1.reg_write, b1.reg_dst, b1.mem_to_reg}), 5'b10100);
        // ORI
        nx(); opcode = OP_ORI;
        nx();
        nx(); #1 chk("iex_alu", 32'(b1.alu_control), 3);
        chk("iex_zext_src", 32'({b1.zero_ext, b1.alu_src_a, b1.alu_src_b}), 4'b1110);
        nx(); #1 chk("iwb", 32'({b1.reg_write, b1.reg_dst, b1.mem_to_reg}), 5'b10000);
        // SW
        nx(); opcode = OP_SW;
        nx();
        nx();
        nx(); #1 chk("memwr", 32'({b1.mem_req, b1.mem_we, b1.iord, b1.reg_write}), 4'b1110);
        // illegal opcode
        nx(); opcode = 6'b111111;
        nx();
        nx(); #1 chk("trap_u1", 32'({b1.illegal, b1.mem_req, b1.halted}), 3'b100);
        chk("trap_u0", 32'({b0.illegal, b0.mem_req, b0.halted}), 3'b101);
        nx(); opcode = OP_RTYPE; funct = F_JR;
        #1 chk("resume_u1", 32'({b1.illegal, b1.mem_req}), 2'b11);
        chk("halt_u0", 32'({b0.mem_req, b0.halted}), 2'b01);
        nx();
        nx(); #1 chk("jr", 32'({b1.pc_write, b1.pc_source, b1.illegal}), 4'b1111);
        // reset mid-fetch, then timeout on u0
        nx(); mem_ready = 1'b0;
        #1 chk("pre_rst_req", 32'(b1.mem_req), 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_o1", 32'(o1), 0);
        chk("rst_async_o0", 32'(o0), 0);
        nx(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nx(); #1 chk("tmo_wait_u0", 32'({b0.mem_req, b0.mem_err, b0.halted}), 3'b100);
        end
        nx(); #1 chk("tmo_trap_u0", 32'({b0.mem_req, b0.mem_err, b0.halted, b0.illegal}), 4'b0110);
        chk("tmo_u1_wait", 32'({b1.mem_req, b1.mem_err}), 2'b10);
        nx(); #1 chk("tmo_stay_u0", 32'({b0.mem_req, b0.mem_err, b0.halted}), 3'b011);
        #4 rst_n = 1'b0;
        #1 chk("rst_req_drop", 32'(b1.mem_req), 0);
        chk("rst_clr_err", 32'(b0.mem_err), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit that replaces the single-cycle decoder. It sequences each instruction through a Moore FSM: fetch, decode, execute, memory and writeback. It drives the shared-memory datapath (one memory port, PC/IR/MDR/ALUOut registers) and waits on a ready handshake for variable-latency memory. Illegal instructions and memory timeouts are trapped, with sticky status flags.

## Interface
- MEM_TIMEOUT, 255: max consecutive wait cycles per memory request before trap; 0 disables timeout
- HALT_ON_ILLEGAL, 1: 1 = TRAP is terminal; 0 = TRAP lasts one cycle then resumes at FETCH
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts/returns data this cycle
- mem_req, mem_we  out  1  memory request / write enable
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write, pc_write, reg_write  out  1  register enables
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = ext imm, 3 = sign-ext imm << 2
- zero_ext  out  1  immediate zero-extended (ANDI/ORI/XORI)
- alu_control  out  4  ALU op code
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A
- illegal, mem_err, halted  out  1  sticky illegal-instr / timeout flags; halted while in terminal TRAP

## Operation
- Outputs are combinational from state (Moore), plus mem_ready gating where noted. Any output not listed for a state is 0.
- BOOT (reset state): all outputs 0 → FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, ADD, pc_source=0.
  - ir_write and pc_write = mem_ready.
  - On mem_ready → DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state:
  - LW/SW → MEMADR
  - R-type → RTYPE_EX; funct 001000 → JR
  - BEQ/BNE → BRANCH
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI → IMM_EX
  - J → JUMP; JAL → JAL
  - anything else → TRAP with illegal set
- MEMADR: alu_src_a=1, alu_src_b=2, ADD → MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req=1, iord=1; on mem_ready → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; on mem_ready → FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=0, alu_control from funct → RTYPE_WB. An undefined funct → TRAP with illegal set.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=2, alu_control from opcode, zero_ext for ANDI/ORI/XORI → IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1, pc_write = zero XOR is_bne → FETCH.
- JUMP: pc_write=1, pc_source=2 → FETCH.
- JAL: as JUMP, plus reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4) → FETCH.
- JR: pc_write=1, pc_source=3 → FETCH.
- TRAP: all datapath outputs 0.
  - HALT_ON_ILLEGAL=1: remain in TRAP, halted=1.
  - Otherwise → FETCH next cycle.
- ALU codes (funct/opcode mapping):
  - 0000 ADD/ADDU/ADDI/ADDIU/LW/SW
  - 0001 SUB/SUBU/BEQ/BNE
  - 0010 AND/ANDI; 0011 OR/ORI; 0100 XOR/XORI
  - 0101 SLL; 0110 SRL; 0111 SRA
  - 1000 SLT/SLTI; 1001 SLTU/SLTIU; 1010 NOR
  - 1011 SLLV; 1100 SRLV; 1101 SRAV
  - 1110 LUI
- illegal and mem_err are cleared only by rst_n.

## Timing
- rst_n low: state = BOOT immediately (asynchronous); all outputs 0, including the sticky flags. BOOT lasts exactly one cycle after release.
- Zero-wait latency in cycles:
  - R-type 4, immediate 4
  - LW 5, SW 4
  - BEQ/BNE 3, J/JAL/JR 3
- Each wait cycle adds one cycle per memory access.
- Handshake:
  - mem_req stays high, with address/we stable, until mem_ready is sampled high.
  - The transfer and the state exit happen on that edge.
  - mem_ready outside a request is ignored.
- Wait counter (width $clog2(MEM_TIMEOUT+1)):
  - Increments each cycle with mem_req=1 and mem_ready=0; cleared when the request completes.
  - When it reaches MEM_TIMEOUT (if nonzero): → TRAP, mem_err=1, no ir_write/pc_write.
  - mem_ready arriving in the same cycle the count would hit the limit completes normally.
- Reset mid-request abandons it; mem_req drops asynchronously.

## Structure
- Package mips_ctrl_pkg: state enum, ALU code localparams, opcode/funct localparams, reg_dst/mem_to_reg/alu_src_b/pc_source encodings.
- Sub-module mips_alu_decode: combinational opcode/funct → alu_control, zero_ext, funct_valid. The FSM, wait counter and sticky flags stay in the top module.

## Test plan
- Reset with mem_ready=1: all outputs 0 while rst_n=0. One BOOT cycle after release, then mem_req=1, iord=0.
- LW, zero-wait: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 only in cycle 5; next cycle mem_req=1 (FETCH).
- FETCH with mem_ready low for 3 cycles: mem_req high for 4 cycles; ir_write and pc_write pulse once, in cycle 4.
- BNE with zero=0 → pc_write=1, pc_source=1. BEQ with zero=0 → pc_write=0. JAL → reg_dst=2, mem_to_reg=2, pc_write=1.
- MEM_TIMEOUT=4 with mem_ready held low: TRAP after 4 wait cycles; mem_err=1, halted=1, mem_req=0 thereafter.
- HALT_ON_ILLEGAL=0, opcode 111111: illegal=1, one TRAP cycle, then FETCH; illegal stays 1 until rst_n.
